// File: rtl/logic_accum_unit.sv
// W-bit bitwise logic unit (AND/OR/XOR/NAND) with a valid/ready stream interface.
// Pairwise mode registers A op B per beat; accumulate mode folds up to DEPTH beats into one result.
module logic_accum_unit #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   input  logic [1:0]    OP,
   input  logic          MODE,
   input  logic          LAST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   output logic [W-1:0]  Y,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [CW-1:0] CNT
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_OUT = 2'd2} state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH-1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [W-1:0]  r_acc;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_op;
   logic          r_mode;

   logic          w_accept;
   logic          w_first_done;
   logic          w_acc_done;
   logic          w_load_first;
   logic          w_load_acc;
   logic          w_clear;
   logic [W-1:0]  w_first_val;
   logic [W-1:0]  w_fold_val;

   function automatic logic [W-1:0] f_op(input logic [1:0] op,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
      case (op)
         2'b00:   f_op = x & y;
         2'b01:   f_op = x | y;
         2'b10:   f_op = x ^ y;
         default: f_op = ~(x & y);
      endcase
   endfunction

   assign w_accept     = IN_VALID && IN_READY;
   // A beat arriving in IDLE or while the result drains starts a new frame with fresh OP/MODE.
   assign w_load_first = w_accept && (r_state != S_ACC);
   assign w_load_acc   = w_accept && (r_state == S_ACC);
   assign w_clear      = (r_state == S_OUT) && OUT_READY && !IN_VALID;
   assign w_first_done = !MODE || (DEPTH == 1) || LAST;
   assign w_acc_done   = LAST || (r_cnt == CNT_LAST) || !r_mode;
   assign w_first_val  = f_op(OP, A, B);
   assign w_fold_val   = f_op(r_op, r_acc, A);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_first_done ? S_OUT : S_ACC;
         S_ACC:  if (w_accept) w_state_nxt = w_acc_done ? S_OUT : S_ACC;
         S_OUT: begin
            if (OUT_READY) begin
               if (IN_VALID) w_state_nxt = w_first_done ? S_OUT : S_ACC;
               else          w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode: purely from state, except the drain-time pass-through of OUT_READY
   always_comb begin
      IN_READY  = 1'b1;
      OUT_VALID = 1'b0;
      if (r_state == S_OUT) begin
         IN_READY  = OUT_READY;
         OUT_VALID = 1'b1;
      end
   end

   // Datapath: accumulator, beat counter and per-frame latches
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_op   <= 2'b00;
         r_mode <= 1'b0;
      end else if (w_load_first) begin
         r_acc  <= w_first_val;
         r_cnt  <= CW'(1);
         r_op   <= OP;
         r_mode <= MODE;
      end else if (w_load_acc) begin
         r_acc  <= w_fold_val;
         r_cnt  <= r_cnt + CW'(1);
      end else if (w_clear) begin
         r_cnt  <= '0;
      end
   end

   assign Y   = r_acc;
   assign CNT = r_cnt;

endmodule

// File: tb/tb_logic_accum_unit.sv
// Directed bench for logic_accum_unit: reset, pairwise, backpressure, accumulate, early LAST, mid-frame reset.
module tb_logic_accum_unit;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] A, B, Y;
   logic [1:0] OP;
   logic       MODE, LAST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
   logic [2:0] CNT;

   int n_pass = 0;
   int n_tot  = 0;

   logic_accum_unit #(.W(8), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .OP(OP), .MODE(MODE), .LAST(LAST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Y(Y), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .CNT(CNT)
   );

   always #5 CLK = ~CLK;

   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic mode, input logic last);
      A = a; B = b; OP = op; MODE = mode; LAST = last; IN_VALID = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1; A = '0; B = '0; OP = '0; MODE = 0; LAST = 0; IN_VALID = 0; OUT_READY = 0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK); beat(8'hFF, 8'h0F, 2'b00, 1'b0, 1'b0);
      @(negedge CLK); IN_VALID = 0;
      n_tot++; if (Y !== 8'h0F) $display("FAIL rst_pre_y got %h exp %h", Y, 8'h0F); else n_pass++;
      #2 RST = 1'b1;
      #1;
      n_tot++; if (Y !== 8'h00) $display("FAIL rst_y got %h exp %h", Y, 8'h00); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL rst_ov got %b exp 0", OUT_VALID); else n_pass++;
      n_tot++; if (CNT !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", CNT); else n_pass++;
      n_tot++; if (IN_READY !== 1'b1) $display("FAIL rst_ir got %b exp 1", IN_READY); else n_pass++;
      @(negedge CLK); RST = 1'b0;
   endtask

   task automatic test_pairwise_b2b();
      logic [7:0] av [3] = '{8'hF0, 8'hFF, 8'hAA};
      logic [7:0] bv [3] = '{8'h3C, 8'h0F, 8'h55};
      logic [7:0] ev [3] = '{8'h30, 8'h0F, 8'h00};
      OUT_READY = 1'b1;
      @(negedge CLK); beat(av[0], bv[0], 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_tot++; if (Y !== ev[i]) $display("FAIL b2b_y%0d got %h exp %h", i, Y, ev[i]); else n_pass++;
         n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL b2b_ov%0d got %b exp 1", i, OUT_VALID); else n_pass++;
         n_tot++; if (CNT !== 3'd1) $display("FAIL b2b_cnt%0d got %0d exp 1", i, CNT); else n_pass++;
         if (i < 2) beat(av[i+1], bv[i+1], 2'b00, 1'b0, 1'b0);
         else IN_VALID = 1'b0;
      end
      @(negedge CLK);
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL b2b_idle_ov got %b exp 0", OUT_VALID); else n_pass++;
   endtask

   task automatic test_backpressure();
      OUT_READY = 1'b0;
      beat(8'h5A, 8'hFF, 2'b10, 1'b0, 1'b0);
      @(negedge CLK); beat(8'h01, 8'h01, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_tot++; if (Y !== 8'hA5) $display("FAIL bp_y%0d got %h exp %h", i, Y, 8'hA5); else n_pass++;
         n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL bp_ov%0d got %b exp 1", i, OUT_VALID); else n_pass++;
         n_tot++; if (IN_READY !== 1'b0) $display("FAIL bp_ir%0d got %b exp 0", i, IN_READY); else n_pass++;
         @(negedge CLK);
      end
      OUT_READY = 1'b1;
      #1;
      n_tot++; if (IN_READY !== 1'b1) $display("FAIL bp_ir_pass got %b exp 1", IN_READY); else n_pass++;
      @(negedge CLK);
      n_tot++; if (Y !== 8'h00) $display("FAIL bp_pend_y got %h exp %h", Y, 8'h00); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL bp_pend_ov got %b exp 1", OUT_VALID); else n_pass++;
      IN_VALID = 1'b0;
      @(negedge CLK);
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL bp_drain_ov got %b exp 0", OUT_VALID); else n_pass++;
      n_tot++; if (CNT !== 3'd0) $display("FAIL bp_drain_cnt got %0d exp 0", CNT); else n_pass++;
      n_tot++; if (Y !== 8'h00) $display("FAIL bp_drain_y got %h exp %h", Y, 8'h00); else n_pass++;
   endtask

   task automatic test_accumulate();
      OUT_READY = 1'b1;
      beat(8'h01, 8'h02, 2'b01, 1'b1, 1'b0);
      @(negedge CLK); IN_VALID = 1'b0;
      @(negedge CLK);
      n_tot++; if (CNT !== 3'd1) $display("FAIL acc_cnt1 got %0d exp 1", CNT); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL acc_ov1 got %b exp 0", OUT_VALID); else n_pass++;
      beat(8'h04, 8'hFF, 2'b00, 1'b1, 1'b0);
      @(negedge CLK); beat(8'h08, 8'h00, 2'b11, 1'b0, 1'b0);
      @(negedge CLK); IN_VALID = 1'b0;
      n_tot++; if (CNT !== 3'd3) $display("FAIL acc_cnt3 got %0d exp 3", CNT); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL acc_ov3 got %b exp 0", OUT_VALID); else n_pass++;
      @(negedge CLK); beat(8'h10, 8'h00, 2'b10, 1'b0, 1'b0);
      @(negedge CLK); IN_VALID = 1'b0;
      n_tot++; if (Y !== 8'h1F) $display("FAIL acc_y got %h exp %h", Y, 8'h1F); else n_pass++;
      n_tot++; if (CNT !== 3'd4) $display("FAIL acc_cnt4 got %0d exp 4", CNT); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL acc_ov4 got %b exp 1", OUT_VALID); else n_pass++;
      @(negedge CLK);
   endtask

   task automatic test_early_last();
      beat(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b0);
      @(negedge CLK); beat(8'h0F, 8'h00, 2'b11, 1'b1, 1'b1);
      n_tot++; if (Y !== 8'h00) $display("FAIL last_acc1 got %h exp %h", Y, 8'h00); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL last_ov1 got %b exp 0", OUT_VALID); else n_pass++;
      @(negedge CLK); IN_VALID = 1'b0; LAST = 1'b0;
      n_tot++; if (Y !== 8'hFF) $display("FAIL last_y got %h exp %h", Y, 8'hFF); else n_pass++;
      n_tot++; if (CNT !== 3'd2) $display("FAIL last_cnt got %0d exp 2", CNT); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL last_ov got %b exp 1", OUT_VALID); else n_pass++;
      @(negedge CLK);
   endtask

   task automatic test_reset_midframe();
      beat(8'hFF, 8'hF0, 2'b00, 1'b1, 1'b0);
      @(negedge CLK); beat(8'h3C, 8'h00, 2'b00, 1'b1, 1'b0);
      @(negedge CLK); IN_VALID = 1'b0;
      n_tot++; if (CNT !== 3'd2) $display("FAIL rmf_cnt_pre got %0d exp 2", CNT); else n_pass++;
      n_tot++; if (Y !== 8'h30) $display("FAIL rmf_acc_pre got %h exp %h", Y, 8'h30); else n_pass++;
      #2 RST = 1'b1;
      #1;
      n_tot++; if (OUT_VALID !== 1'b0) $display("FAIL rmf_ov got %b exp 0", OUT_VALID); else n_pass++;
      n_tot++; if (CNT !== 3'd0) $display("FAIL rmf_cnt got %0d exp 0", CNT); else n_pass++;
      @(negedge CLK); RST = 1'b0;
      beat(8'hC3, 8'h81, 2'b00, 1'b0, 1'b0);
      @(negedge CLK); IN_VALID = 1'b0;
      n_tot++; if (Y !== 8'h81) $display("FAIL rmf_y got %h exp %h", Y, 8'h81); else n_pass++;
      n_tot++; if (CNT !== 3'd1) $display("FAIL rmf_cnt_new got %0d exp 1", CNT); else n_pass++;
      n_tot++; if (OUT_VALID !== 1'b1) $display("FAIL rmf_ov_new got %b exp 1", OUT_VALID); else n_pass++;
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_pairwise_b2b();
      test_backpressure();
      test_accumulate();
      test_early_last();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
